// File: rtl/fft_bfly_ctrl_pkg.sv
// Shared definitions for the FFT butterfly datapath and its sequencer:
// word geometry, Q9.6 fraction width and the controller state encoding.
package fft_bfly_ctrl_pkg;

  localparam int unsigned DEF_WORD_SZ  = 32;
  localparam int unsigned DEF_WORD_MID = 16;
  localparam int unsigned FRAC_BITS    = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage s, butterfly k) to
// operand addresses a/b and twiddle ROM index tw.
module fft_addr_gen #(
  parameter int unsigned N_LOG2 = 3,
  parameter int unsigned S_W    = $clog2(N_LOG2)
) (
  input  logic [S_W-1:0]    s,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] a,
  output logic [N_LOG2-1:0] b,
  output logic [N_LOG2-2:0] tw
);

  logic [N_LOG2-1:0] k_ext;
  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] grp;
  logic [S_W-1:0]    tw_sh;

  always_comb begin
    k_ext = {1'b0, k};
    span  = N_LOG2'(1) << s;
    pos   = k_ext & (span - N_LOG2'(1));
    grp   = k_ext >> s;
    a     = ((grp << s) << 1) | pos;
    // bit s of a is always clear, so OR-ing span is the same as a + span
    b     = a | span;
    tw_sh = S_W'(N_LOG2 - 1) - s;
    tw    = (N_LOG2-1)'(pos << tw_sh);
  end

endmodule

// File: rtl/fft_bfly_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: reads operand pairs and twiddle,
// feeds the external butterfly, and writes its results back, one per 3 cycles.
module fft_bfly_ctrl
  import fft_bfly_ctrl_pkg::*;
#(
  parameter int unsigned N_LOG2   = 3,
  parameter int unsigned WORD_SZ  = DEF_WORD_SZ,
  parameter int unsigned WORD_MID = DEF_WORD_MID
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [N_LOG2-1:0]   o_rd_addr_a,
  output logic [N_LOG2-1:0]   o_rd_addr_b,
  input  logic [WORD_SZ-1:0]  i_rd_data_a,
  input  logic [WORD_SZ-1:0]  i_rd_data_b,
  output logic [N_LOG2-2:0]   o_tw_addr,
  input  logic [WORD_SZ-1:0]  i_tw_data,
  output logic [WORD_SZ-1:0]  o_bf_A,
  output logic [WORD_SZ-1:0]  o_bf_B,
  output logic [WORD_SZ-1:0]  o_bf_twiddle,
  input  logic [WORD_SZ-1:0]  i_bf_A,
  input  logic [WORD_SZ-1:0]  i_bf_B,
  output logic                o_wr_en,
  output logic [N_LOG2-1:0]   o_wr_addr_a,
  output logic [N_LOG2-1:0]   o_wr_addr_b,
  output logic [WORD_SZ-1:0]  o_wr_data_a,
  output logic [WORD_SZ-1:0]  o_wr_data_b
);

  localparam int unsigned S_W = $clog2(N_LOG2);

  state_t            state, state_nxt;
  logic [S_W-1:0]    s_q;
  logic [N_LOG2-2:0] k_q;
  logic [N_LOG2-1:0] addr_a, addr_b;
  logic [N_LOG2-2:0] addr_tw;
  logic              k_last, s_last;

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .s  (s_q),
    .k  (k_q),
    .a  (addr_a),
    .b  (addr_b),
    .tw (addr_tw)
  );

  assign k_last = &k_q;
  assign s_last = (s_q == S_W'(N_LOG2 - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_wr_en      = 1'b0;
    o_rd_addr_a  = '0;
    o_rd_addr_b  = '0;
    o_tw_addr    = '0;
    o_bf_A       = '0;
    o_bf_B       = '0;
    o_bf_twiddle = '0;
    unique case (state)
      ST_IDLE: if (i_start) state_nxt = ST_READ;
      ST_READ: begin
        o_busy      = 1'b1;
        o_rd_addr_a = addr_a;
        o_rd_addr_b = addr_b;
        o_tw_addr   = addr_tw;
        state_nxt   = ST_CALC;
      end
      ST_CALC: begin
        o_busy       = 1'b1;
        o_bf_A       = {i_rd_data_a[WORD_SZ-1:WORD_MID], i_rd_data_a[WORD_MID-1:0]};
        o_bf_B       = {i_rd_data_b[WORD_SZ-1:WORD_MID], i_rd_data_b[WORD_MID-1:0]};
        o_bf_twiddle = {i_tw_data[WORD_SZ-1:WORD_MID], i_tw_data[WORD_MID-1:0]};
        state_nxt    = ST_WRITE;
      end
      ST_WRITE: begin
        o_busy    = 1'b1;
        o_wr_en   = 1'b1;
        state_nxt = (k_last && s_last) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage/butterfly counters and the write-back registers; addresses are
  // latched in CALC so they stay stable while the counters advance in WRITE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_q         <= '0;
      k_q         <= '0;
      o_wr_addr_a <= '0;
      o_wr_addr_b <= '0;
      o_wr_data_a <= '0;
      o_wr_data_b <= '0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        s_q <= '0;
        k_q <= '0;
      end
      if (state == ST_CALC) begin
        o_wr_addr_a <= addr_a;
        o_wr_addr_b <= addr_b;
        o_wr_data_a <= i_bf_A;
        o_wr_data_b <= i_bf_B;
      end
      if (state == ST_WRITE) begin
        if (!k_last) begin
          k_q <= k_q + 1'b1;
        end else if (!s_last) begin
          s_q <= s_q + 1'b1;
          k_q <= '0;
        end
      end
    end
  end

endmodule
